// File: rtl/timer_pkg.sv
// Shared constants and state type for the APB-style timer peripheral.
//   - register addresses on the 2-bit bus address
//   - bit positions inside the STATUS register
//   - e_timer_state, whose encoding is the value software sees in STATE
package timer_pkg;

    localparam logic [1:0] STATUS_ADDR = 2'd0;
    localparam logic [1:0] GOAL_ADDR   = 2'd1;
    localparam logic [1:0] CURR_ADDR   = 2'd2;

    localparam int STATUS_START     = 0;
    localparam int STATUS_STOP      = 1;
    localparam int STATUS_STATE_LSB = 2;
    localparam int STATE_LEN        = 2;

    typedef enum logic [STATE_LEN-1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        COMPLETE = 2'd2,
        PAUSED   = 2'd3
    } e_timer_state;

endpackage

// File: rtl/timer.sv
// Single up-counting timer with a programmable goal. It is a zero-wait-state
// APB-style slave with four register words.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-high reset
//   sel     slave select (PSEL)
//   enable  access phase (PENABLE)
//   write   1 = write, 0 = read
//   addr    register address: 0 STATUS, 1 GOAL, 2 CURR, 3 invalid
//   wdata   write data
//   rdata   read data, driven only during a valid read access
//   ready   transfer complete (PREADY), sel & enable
//   slverr  transfer error (PSLVERR): invalid address or write to CURR
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | not counting, waiting for START
// RUNNING  | CURR increments each edge until it reaches GOAL
// COMPLETE | goal reached, CURR held; a STATUS read returns to IDLE
// PAUSED   | STOP while running, CURR held; START resumes
module timer
    import timer_pkg::*;
#(
    parameter int timerbits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 enable,
    input  logic                 write,
    input  logic [1:0]           addr,
    input  logic [timerbits-1:0] wdata,
    output logic [timerbits-1:0] rdata,
    output logic                 ready,
    output logic                 slverr
);

    e_timer_state         state_q, state_d;
    logic [timerbits-1:0] goal_q, goal_d;
    logic [timerbits-1:0] curr_q, curr_d;

    logic                 access;
    logic                 err;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [timerbits-1:0] status_word;

    // Outputs are forced low during reset so the bus sees a clean idle slave.
    assign access = sel & enable & ~reset;
    assign err    = (addr == 2'd3) || (write && (addr == CURR_ADDR));
    assign wr_ok  = access & write & ~err;
    assign rd_ok  = access & ~write & ~err;
    assign ready  = access;
    assign slverr = access & err;

    always_comb begin
        status_word = '0;
        status_word[STATUS_STATE_LSB +: STATE_LEN] = state_q;
    end

    always_comb begin
        rdata = '0;
        if (rd_ok) begin
            case (addr)
                STATUS_ADDR: rdata = status_word;
                GOAL_ADDR:   rdata = goal_q;
                CURR_ADDR:   rdata = curr_q;
                default:     rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            goal_q  <= '0;
            curr_q  <= '0;
        end else begin
            state_q <= state_d;
            goal_q  <= goal_d;
            curr_q  <= curr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        goal_d  = goal_q;
        curr_d  = curr_q;

        // Compare against GOAL as it was before this edge. Using >= means that
        // lowering GOAL below CURR completes on the next edge.
        if (state_q == RUNNING) begin
            if (curr_q >= goal_q) begin
                state_d = COMPLETE;
            end else begin
                curr_d = curr_q + 1'b1;
            end
        end

        if (wr_ok && (addr == GOAL_ADDR)) begin
            goal_d = wdata;
        end

        // A STATUS write overrides the counting step that would otherwise
        // happen on the same edge. STOP wins over START.
        if (wr_ok && (addr == STATUS_ADDR)) begin
            if (wdata[STATUS_STOP]) begin
                if (state_q == RUNNING) begin
                    state_d = PAUSED;
                    curr_d  = curr_q;
                end
            end else if (wdata[STATUS_START]) begin
                state_d = RUNNING;
                if (state_q != PAUSED) begin
                    curr_d = '0;
                end else begin
                    curr_d = curr_q;
                end
            end
        end

        // Reading STATUS in COMPLETE acknowledges completion.
        if (rd_ok && (addr == STATUS_ADDR) && (state_q == COMPLETE)) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic       enable = 1'b0;
    logic       write = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       ready;
    logic       slverr;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers following the register-level rules.
    int m_state = 0;
    int m_goal = 0;
    int m_curr = 0;

    logic [7:0] o_rd, x_rd;
    logic       o_rdy, x_rdy, o_err, x_err;

    timer #(.timerbits(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .enable (enable),
        .write  (write),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .slverr (slverr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_goal = 0;
        m_curr = 0;
    endtask

    task automatic model_edge(input logic s, input logic e, input logic w,
                              input logic [1:0] a, input logic [7:0] wd);
        bit acc = s && e;
        bit bad = (a == 2'd3) || (w && a == 2'd2);
        int ns = m_state;
        int nc = m_curr;
        int ng = m_goal;
        if (m_state == 1) begin
            if (m_curr >= m_goal) ns = 2;
            else nc = m_curr + 1;
        end
        if (acc && !bad && w && a == 2'd1) ng = wd;
        if (acc && !bad && w && a == 2'd0) begin
            if (wd[1]) begin
                if (m_state == 1) begin
                    ns = 3;
                    nc = m_curr;
                end
            end else if (wd[0]) begin
                ns = 1;
                if (m_state != 3) nc = 0;
                else nc = m_curr;
            end
        end
        if (acc && !bad && !w && a == 2'd0 && m_state == 2) ns = 0;
        m_state = ns;
        m_curr = nc;
        m_goal = ng;
    endtask

    // Drives one bus cycle, samples outputs mid-cycle into o_*, computes the
    // model's expectation into x_*, then advances the model at the edge.
    task automatic bus(input logic s, input logic e, input logic w,
                       input logic [1:0] a, input logic [7:0] wd);
        bit acc;
        bit bad;
        sel = s; enable = e; write = w; addr = a; wdata = wd;
        @(negedge clk);
        o_rd = rdata; o_rdy = ready; o_err = slverr;
        acc = s && e;
        bad = (a == 2'd3) || (w && a == 2'd2);
        x_rdy = acc;
        x_err = acc && bad;
        x_rd = 8'h00;
        if (acc && !bad && !w) begin
            case (a)
                2'd0: x_rd = 8'(m_state * 4);
                2'd1: x_rd = 8'(m_goal);
                2'd2: x_rd = 8'(m_curr);
                default: x_rd = 8'h00;
            endcase
        end
        @(posedge clk);
        model_edge(s, e, w, a, wd);
        #1;
        sel = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = 2'd0;
        #1;
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++;
        if (slverr !== 1'b0) begin failures++; $display("FAIL reset_slverr got=%b exp=0", slverr); end
        checks++;
        if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        sel = 1'b0; enable = 1'b0;
        do_reset();
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL reset_state got=%h exp=00", o_rd); end
        bus(1, 1, 0, 2'd1, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL reset_goal got=%h exp=00", o_rd); end
        bus(1, 1, 0, 2'd2, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL reset_curr got=%h exp=00", o_rd); end
    endtask

    task automatic test_invalid();
        for (int k = 0; k < 2; k++) begin
            bus(1, 1, (k == 0), 2'd3, 8'hFF);
            checks++;
            if (o_rdy !== 1'b1 || o_err !== 1'b1 || o_rd !== 8'h00) begin
                failures++;
                $display("FAIL invalid_addr rdy=%b err=%b rd=%h exp rdy=1 err=1 rd=00", o_rdy, o_err, o_rd);
            end
        end
        for (int a = 0; a < 3; a++) begin
            bus(1, 1, 0, 2'(a), 8'h00);
            checks++;
            if (o_rd !== 8'h00) begin failures++; $display("FAIL invalid_side_effect addr=%0d got=%h exp=00", a, o_rd); end
        end
    endtask

    task automatic test_gating();
        bus(0, 1, 1, 2'd0, 8'h01);
        checks++;
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL gating_nosel_ready got=%b exp=0", o_rdy); end
        bus(1, 0, 1, 2'd0, 8'h01);
        checks++;
        if (o_rdy !== 1'b0) begin failures++; $display("FAIL gating_noen_ready got=%b exp=0", o_rdy); end
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL gating_state got=%h exp=00", o_rd); end
        bus(1, 1, 0, 2'd2, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL gating_curr got=%h exp=00", o_rd); end
    endtask

    task automatic test_full_count();
        logic [7:0] c0, c1;
        bus(1, 1, 1, 2'd1, 8'd25);
        bus(1, 1, 1, 2'd0, 8'h01);
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h04) begin failures++; $display("FAIL count_running got=%h exp=04", o_rd); end
        bus(1, 1, 0, 2'd2, 8'h00);
        c0 = o_rd;
        idle(1);
        bus(1, 1, 0, 2'd2, 8'h00);
        c1 = o_rd;
        checks++;
        if (!(c1 > c0)) begin failures++; $display("FAIL count_increase got=%0d then %0d exp increasing", c0, c1); end
        idle(30);
        bus(1, 1, 0, 2'd2, 8'h00);
        checks++;
        if (o_rd !== 8'd25) begin failures++; $display("FAIL count_final_curr got=%0d exp=25", o_rd); end
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h08) begin failures++; $display("FAIL count_complete got=%h exp=08", o_rd); end
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL count_read_clear got=%h exp=00", o_rd); end
    endtask

    task automatic test_pause();
        logic [7:0] h0, h1;
        bus(1, 1, 1, 2'd1, 8'd25);
        bus(1, 1, 1, 2'd0, 8'h01);
        idle(5);
        bus(1, 1, 1, 2'd0, 8'h03);
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h0C) begin failures++; $display("FAIL pause_state got=%h exp=0c", o_rd); end
        bus(1, 1, 0, 2'd2, 8'h00);
        h0 = o_rd;
        bus(1, 1, 0, 2'd2, 8'h00);
        h1 = o_rd;
        checks++;
        if (h1 !== h0 || h0 !== 8'(m_curr)) begin
            failures++;
            $display("FAIL pause_hold got=%0d,%0d exp=%0d", h0, h1, m_curr);
        end
        bus(1, 1, 1, 2'd0, 8'h01);
        idle(2);
        bus(1, 1, 0, 2'd2, 8'h00);
        checks++;
        if (o_rd !== h0 + 8'd2) begin failures++; $display("FAIL pause_resume got=%0d exp=%0d", o_rd, h0 + 8'd2); end
        bus(1, 1, 1, 2'd0, 8'h02);
        bus(1, 1, 0, 2'd2, 8'h00);
        h0 = o_rd;
        bus(1, 1, 1, 2'd2, 8'h5A);
        checks++;
        if (o_err !== 1'b1 || o_rdy !== 1'b1) begin failures++; $display("FAIL curr_write_err err=%b rdy=%b exp err=1 rdy=1", o_err, o_rdy); end
        bus(1, 1, 0, 2'd2, 8'h00);
        checks++;
        if (o_rd !== h0) begin failures++; $display("FAIL curr_write_unchanged got=%0d exp=%0d", o_rd, h0); end
    endtask

    task automatic test_goal_zero();
        do_reset();
        bus(1, 1, 1, 2'd1, 8'd0);
        bus(1, 1, 1, 2'd0, 8'h01);
        idle(1);
        bus(1, 1, 0, 2'd2, 8'h00);
        checks++;
        if (o_rd !== 8'h00) begin failures++; $display("FAIL goal0_curr got=%h exp=00", o_rd); end
        bus(1, 1, 0, 2'd0, 8'h00);
        checks++;
        if (o_rd !== 8'h08) begin failures++; $display("FAIL goal0_complete got=%h exp=08", o_rd); end
    endtask

    task automatic test_mid_reset();
        bus(1, 1, 1, 2'd1, 8'd50);
        bus(1, 1, 1, 2'd0, 8'h01);
        idle(5);
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = 2'd2;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || rdata !== 8'h00 || slverr !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs rdy=%b rd=%h err=%b exp 0/00/0", ready, rdata, slverr);
        end
        sel = 1'b0; enable = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int a = 0; a < 3; a++) begin
            bus(1, 1, 0, 2'(a), 8'h00);
            checks++;
            if (o_rd !== 8'h00) begin failures++; $display("FAIL midreset_reg addr=%0d got=%h exp=00", a, o_rd); end
        end
    endtask

    task automatic test_random();
        logic s, e, w;
        logic [1:0] a;
        logic [7:0] wd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd1) wd = 8'($urandom_range(0, 20));
            else wd = 8'($urandom);
            bus(s, e, w, a, wd);
            checks++;
            if (o_rd !== x_rd || o_rdy !== x_rdy || o_err !== x_err) begin
                failures++;
                $display("FAIL random i=%0d rd=%h rdy=%b err=%b exp rd=%h rdy=%b err=%b",
                         i, o_rd, o_rdy, o_err, x_rd, x_rdy, x_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalid();
        test_gating();
        test_full_count();
        test_pause();
        test_goal_zero();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- APB-style slave peripheral containing one up-counting timer with a programmable goal.
- Software writes a goal value, starts and pauses the counter, reads the live count, and polls a status field.
- The status field reports idle, running, complete or paused.
- Sits on the peripheral bus as a single 4-word register slave.

Parameters:
- timerbits, 8, width of the data bus and of the GOAL and CURR registers. Minimum 4, so status bits [3:2] fit.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sel  input  1  slave select (PSEL).
- enable  input  1  access phase (PENABLE).
- write  input  1  1 = write, 0 = read.
- addr  input  2  register address.
- wdata  input  timerbits  write data.
- rdata  output  timerbits  read data.
- ready  output  1  transfer complete (PREADY).
- slverr  output  1  transfer error (PSLVERR).

Behaviour:
- Register map:
  - 0 = STATUS: bit0 START (write-only, reads 0), bit1 STOP (write-only, reads 0), bits[3:2] STATE (read-only), other bits read 0.
  - 1 = GOAL: read/write.
  - 2 = CURR: read-only.
  - 3 = invalid.
- STATE encoding: 0 IDLE, 1 RUNNING, 2 COMPLETE, 3 PAUSED.
- Reset, asynchronous while reset=1:
  - STATE=IDLE, GOAL=0, CURR=0.
  - rdata=0, ready=0, slverr=0.
- Bus handshake, zero wait states:
  - ready = sel & enable (combinational); it is 0 whenever reset=1.
  - A transfer takes effect only on a rising edge where sel=1 and enable=1; no reaction without both.
- Reads: rdata is driven combinationally with the addressed register while sel & enable & !write; otherwise rdata=0.
- Errors: slverr=1 during the access cycle when:
  - addr=3 (read or write), or
  - the access is a write to CURR.
  - Erroring accesses change no state, and rdata=0 for them.
- GOAL write: takes effect at the access edge and applies immediately, even while RUNNING.
- STATUS write, evaluated at the access edge, with STOP taking priority over START:
  - STOP=1 and state RUNNING -> PAUSED. CURR is held.
  - STOP=1 in any other state -> no change.
  - START=1, STOP=0, state PAUSED -> RUNNING. CURR is kept.
  - START=1, STOP=0, state IDLE or COMPLETE -> CURR=0, state RUNNING.
  - START=1, STOP=0, state RUNNING -> restart: CURR=0, state stays RUNNING.
  - START=0 and STOP=0 -> no effect.
- Counting, each edge in RUNNING (not on the edge of a START write):
  - If CURR >= GOAL -> state COMPLETE and CURR holds.
  - Otherwise CURR = CURR + 1.
  - Consequence: with GOAL=0, COMPLETE is reached one cycle after start. With GOAL=N, COMPLETE is reached N+1 edges after start, with CURR=N.
  - A GOAL write below the current CURR completes on the next edge.
  - No wrap-around is possible.
- Read-to-clear: a successful STATUS read in state COMPLETE returns STATE=2, and the state becomes IDLE at that access edge. CURR is unchanged.
- Simultaneous events: a bus write to STATUS at the same edge as the counter reaching the goal follows the write rules above, evaluated against the pre-edge state.

Decomposition:
- Package timer_pkg holds:
  - address constants STATUS_ADDR=0, GOAL_ADDR=1, CURR_ADDR=2;
  - bit indices STATUS_START=0, STATUS_STOP=1, STATUS_STATE_LSB=2, STATE_LEN=2;
  - enum e_timer_state {IDLE, RUNNING, COMPLETE, PAUSED}.
- Implemented as a single module. No sub-module is needed.

Test Plan:
- Invalid address: write 8'hFF and then read at addr 3 -> ready=1, slverr=1, rdata=0; GOAL, CURR and STATE unchanged.
- Protocol gating: a write to STATUS with START=1 with sel=0 (enable=1), then again with enable=0 (sel=1) -> ready=0; STATE stays IDLE and CURR stays 0.
- Full count:
  - Read STATUS after reset -> STATE=0.
  - Write GOAL=25, then write STATUS=8'h01 -> the next STATUS read gives STATE=1, and CURR reads increase between samples.
  - Wait >= 26 cycles -> STATUS read gives STATE=2 and CURR=25.
  - Read STATUS again -> STATE=0.
- Pause: GOAL=25, start, then write STATUS=8'h03 (START+STOP) -> STATE=3; two consecutive CURR reads return identical values. Write STATUS=8'h01 -> counting resumes from the held value.
- Error and edge cases: a write to CURR returns slverr=1 and leaves CURR unchanged. GOAL=0 plus START -> COMPLETE after 1 cycle with CURR=0.
- Reset mid-count: assert reset while RUNNING -> immediately STATE=0, GOAL=0, CURR=0, ready=0.
